beat_timing_gen: RTL and testbench
==================================

BEAT_TIMING_GEN -- requirements
Module: beat_timing_gen

Interface
REQ-001 SHALL have the following ports (name  direction  width  meaning):
- clk  in  1  system clock; all state changes on its rising edge.
- clr  in  1  reset; asynchronous, active-low.
- qd  in  1  raw start push-button, asynchronous.
- int_btn  in  1  raw interrupt push-button, asynchronous.
- short  in  1  controller request: current beat W1 is the last beat of the instruction.
- long  in  1  controller request: insert beat W3 after W2.
- stop  in  1  controller request: halt after the current beat.
- t1, t2, t3  out  1 each  one-hot phase outputs, one clk cycle each.
- w1, w2, w3  out  1 each  one-hot beat outputs to the controller.
- running  out  1  sequencer active.
- pulse  out  1  single-cycle synchronized interrupt request.
- beat_cnt  out  8  count of completed beats.

Function
REQ-002 SHALL pass qd and int_btn through separate 2-flop synchronizers followed by a third flop for rising-edge detection.
REQ-003 SHALL treat qd_edge = sync2 & ~sync3, and int_edge likewise.
REQ-004 SHALL run a two-state FSM, IDLE and RUN; running = (state == RUN).
REQ-005 IDLE -> RUN SHALL occur on the clock edge where qd_edge = 1; t1 SHALL be asserted from that same edge.
REQ-006 qd_edge SHALL be ignored while in RUN, including the cycle in which RUN is being exited.
REQ-007 In RUN, phases SHALL cycle T1 -> T2 -> T3 -> T1, each lasting exactly one clk cycle.
REQ-008 In IDLE, t1 = t2 = t3 = 0.
REQ-009 short, long and stop SHALL be sampled only on the clk edge that ends T3. Values at other times have no effect.
REQ-010 At the end of T3, the beat SHALL advance as follows:
- W1 with short = 1 -> W1.
- W1 with short = 0 -> W2.
- W2 with long = 1 -> W3.
- W2 with long = 0 -> W1.
- W3 -> W1.
REQ-011 If short and long are both 1 in W1, short SHALL win. long SHALL be ignored outside W2.
REQ-012 If stop = 1 at the end of T3:
- the beat SHALL still advance per REQ-010;
- beat_cnt SHALL increment;
- the FSM SHALL enter IDLE.
REQ-013 w1, w2 and w3 SHALL hold their value while in IDLE, so that a restart resumes at the already-advanced beat starting in T1.
REQ-014 Exactly one of w1, w2, w3 SHALL be 1 at all times after reset.
REQ-015 beat_cnt SHALL increment by 1 at each end of T3 and wrap 255 -> 0. It SHALL NOT change in IDLE.
REQ-016 pulse SHALL be 1 for exactly one clk cycle per int_btn rising edge, in the cycle int_edge = 1, independent of FSM state.
REQ-017 Outputs SHALL be registered, not combinational from short, long or stop.

Reset
REQ-018 While clr = 0, the block SHALL hold:
- state IDLE, running = 0;
- t1 = t2 = t3 = 0;
- w1 = 1, w2 = w3 = 0;
- beat_cnt = 0, pulse = 0;
- all synchronizer flops = 0.
REQ-019 clr asserted mid-beat SHALL abort immediately to the REQ-018 values, with no completion of the beat.
REQ-020 After clr is released, the block SHALL remain IDLE until a new qd rising edge, even if qd is held high through reset release. The synchronizers start at 0, so a held-high qd SHALL produce one edge after release.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Reset, then qd high at edge k -> running = 1 and t1 = 1 from edge k+2; w1 = 1; t pattern 100, 010, 001 repeating.
- short = 0 and long = 0 over 4 beats -> w sequence W1, W2, W1, W2; beat_cnt = 4.
- short = 0, long = 1 in W2 -> W1, W2, W3, W1; short = 1 in W1 -> W1, W1.
- stop = 1 during W2 T3 with long = 0 -> running = 0 after that edge; w1 = 1 held; beat_cnt unchanged while idle; next qd -> t1 with w1.
- clr low during W3 T2 -> immediately t = 000, w1 = 1, beat_cnt = 0, running = 0; qd held high across reset release -> exactly one start.
- int_btn held high 50 cycles -> exactly one pulse cycle; beat_cnt wraps 255 -> 0 after 256 beats.

Source files
------------

// File: rtl/beat_timing_gen.sv
// Beat/phase timing generator: synchronized start and interrupt buttons, T1-T3 phase ring, W1-W3 beat sequencer.
// The start edge registers into RUN/T1; controller requests are sampled only on the edge that ends T3.
module beat_timing_gen (
  input  logic       clk,
  input  logic       clr,
  input  logic       qd,
  input  logic       int_btn,
  input  logic       short,
  input  logic       long,
  input  logic       stop,
  output logic       t1,
  output logic       t2,
  output logic       t3,
  output logic       w1,
  output logic       w2,
  output logic       w3,
  output logic       running,
  output logic       pulse,
  output logic [7:0] beat_cnt
);

  typedef enum logic {IDLE, RUN} state_e;

  // bit0/bit1 form the synchronizer, bit2 is the edge-detect history flop
  logic [2:0] qd_sync_q, qd_sync_d;
  logic [2:0] int_sync_q, int_sync_d;
  state_e     state_q, state_d;
  logic [2:0] t_q, t_d;
  logic [2:0] w_q, w_d;
  logic [7:0] cnt_q, cnt_d;
  logic       qd_edge;

  assign qd_edge = qd_sync_q[1] & ~qd_sync_q[2];

  always_comb begin
    qd_sync_d  = {qd_sync_q[1:0], qd};
    int_sync_d = {int_sync_q[1:0], int_btn};
    state_d    = state_q;
    t_d        = t_q;
    w_d        = w_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (qd_edge) begin
          state_d = RUN;
          t_d     = 3'b001;
        end
      end
      RUN: begin
        if (t_q[2]) begin
          cnt_d = cnt_q + 8'd1;
          if (w_q[0])      w_d = short ? 3'b001 : 3'b010;
          else if (w_q[1]) w_d = long  ? 3'b100 : 3'b001;
          else             w_d = 3'b001;
          // A stopped beat still completes; the advanced beat is held for restart
          if (stop) begin
            state_d = IDLE;
            t_d     = 3'b000;
          end else begin
            t_d     = 3'b001;
          end
        end else begin
          t_d = {t_q[1:0], 1'b0};
        end
      end
      default: begin
        state_d = IDLE;
        t_d     = 3'b000;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      qd_sync_q  <= 3'b000;
      int_sync_q <= 3'b000;
      state_q    <= IDLE;
      t_q        <= 3'b000;
      w_q        <= 3'b001;
      cnt_q      <= 8'd0;
    end else begin
      qd_sync_q  <= qd_sync_d;
      int_sync_q <= int_sync_d;
      state_q    <= state_d;
      t_q        <= t_d;
      w_q        <= w_d;
      cnt_q      <= cnt_d;
    end
  end

  assign t1       = t_q[0];
  assign t2       = t_q[1];
  assign t3       = t_q[2];
  assign w1       = w_q[0];
  assign w2       = w_q[1];
  assign w3       = w_q[2];
  assign running  = (state_q == RUN);
  assign pulse    = int_sync_q[1] & ~int_sync_q[2];
  assign beat_cnt = cnt_q;

endmodule

// File: tb/tb_beat_timing_gen.sv
// Directed, table-driven bench for beat_timing_gen.
module tb_beat_timing_gen;

  logic clk = 1'b0;
  logic clr, qd, int_btn, short, long, stop;
  logic t1, t2, t3, w1, w2, w3, running, pulse;
  logic [7:0] beat_cnt;

  int checks = 0;
  int failures = 0;

  beat_timing_gen dut (
    .clk(clk), .clr(clr), .qd(qd), .int_btn(int_btn),
    .short(short), .long(long), .stop(stop),
    .t1(t1), .t2(t2), .t3(t3), .w1(w1), .w2(w2), .w3(w3),
    .running(running), .pulse(pulse), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       s;
    logic       l;
    logic       st;
    logic [2:0] w;     // expected {w3,w2,w1} after the T3-ending edge
    logic [7:0] cnt;
    logic       run;
  } vec_t;

  vec_t vecs [11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string name, input logic run, input logic [2:0] t,
                           input logic [2:0] w, input logic [7:0] cnt);
    chk({name, ".running"}, {31'd0, running}, {31'd0, run});
    chk({name, ".t"}, {29'd0, t3, t2, t1}, {29'd0, t});
    chk({name, ".w"}, {29'd0, w3, w2, w1}, {29'd0, w});
    chk({name, ".cnt"}, {24'd0, beat_cnt}, {24'd0, cnt});
  endtask

  initial begin
    int npulse;

    vecs[0]  = '{1'b0, 1'b0, 1'b0, 3'b010, 8'd1,  1'b1};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 3'b001, 8'd2,  1'b1};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 3'b010, 8'd3,  1'b1};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 3'b001, 8'd4,  1'b1};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 3'b010, 8'd5,  1'b1};  // long ignored in W1
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 3'b100, 8'd6,  1'b1};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 3'b001, 8'd7,  1'b1};  // W3 always returns to W1
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 3'b001, 8'd8,  1'b1};  // short wins over long
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 3'b001, 8'd9,  1'b1};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 3'b010, 8'd10, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 3'b001, 8'd11, 1'b0};  // stop in W2

    clr = 1'b0; qd = 1'b0; int_btn = 1'b0; short = 1'b0; long = 1'b0; stop = 1'b0;
    tick(); tick();
    chk_state("reset", 1'b0, 3'b000, 3'b001, 8'd0);
    chk("reset.pulse", {31'd0, pulse}, 32'd0);
    clr = 1'b1;
    tick();

    // Start: qd seen at edge k, RUN/T1 from edge k+2
    qd = 1'b1;
    tick();
    chk("start.k", {31'd0, running}, 32'd0);
    tick();
    chk("start.k1", {31'd0, running}, 32'd0);
    tick();
    chk_state("start.k2", 1'b1, 3'b001, 3'b001, 8'd0);
    qd = 1'b0;

    for (int i = 0; i < 11; i++) begin
      // Noise during T1/T2 must have no effect
      short = 1'b1; long = 1'b1; stop = 1'b1;
      tick();
      chk($sformatf("v%0d.t2", i), {29'd0, t3, t2, t1}, 32'b010);
      tick();
      chk($sformatf("v%0d.t3", i), {29'd0, t3, t2, t1}, 32'b100);
      short = vecs[i].s; long = vecs[i].l; stop = vecs[i].st;
      tick();
      chk_state($sformatf("v%0d", i), vecs[i].run, vecs[i].run ? 3'b001 : 3'b000,
                vecs[i].w, vecs[i].cnt);
    end

    // Idle: controls toggling must not change anything
    short = 1'b1; long = 1'b1; stop = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk_state("idle.hold", 1'b0, 3'b000, 3'b001, 8'd11);

    // Restart resumes at W1 in T1
    short = 1'b0; long = 1'b0;
    qd = 1'b1;
    tick(); tick(); tick();
    chk_state("restart", 1'b1, 3'b001, 3'b001, 8'd11);
    tick(); tick();
    tick();                          // W1 -> W2
    tick(); tick();
    long = 1'b1;
    tick();                          // W2 -> W3
    long = 1'b0;
    chk_state("to_w3", 1'b1, 3'b001, 3'b100, 8'd13);
    tick();                          // W3 T2

    // Asynchronous reset mid-beat with qd held high
    #2 clr = 1'b0;
    #1;
    chk_state("clr.async", 1'b0, 3'b000, 3'b001, 8'd0);
    tick(); tick();
    #2 clr = 1'b1;
    tick();
    chk("rel.e1", {31'd0, running}, 32'd0);
    tick();
    chk("rel.e2", {31'd0, running}, 32'd0);
    tick();
    chk_state("rel.start", 1'b1, 3'b001, 3'b001, 8'd0);
    tick(); tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_state("rel.stop", 1'b0, 3'b000, 3'b010, 8'd1);
    for (int i = 0; i < 10; i++) tick();
    chk("rel.once", {31'd0, running}, 32'd0);

    // Interrupt held high: exactly one pulse
    npulse = 0;
    int_btn = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (pulse) npulse++;
    end
    int_btn = 1'b0;
    chk("int.pulses", npulse, 32'd1);

    // 256 beats in W1 wrap the counter
    clr = 1'b0;
    tick();
    clr = 1'b1;
    short = 1'b1;
    tick(); tick(); tick();
    chk_state("wrap.start", 1'b1, 3'b001, 3'b001, 8'd0);
    for (int i = 1; i <= 256; i++) begin
      tick(); tick(); tick();
      if (i == 255) chk("wrap.255", {24'd0, beat_cnt}, 32'd255);
      if (i == 256) chk_state("wrap.0", 1'b1, 3'b001, 3'b001, 8'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
